vector_mem_unit: RTL and testbench
==================================

Name: vector_mem_unit

Overview:
- Memory stage that consumes the execute stage's vector result (vect_out) for stores and produces a full vector for loads.
- Serialises one vector to or from a word-wide data memory, one lane per cycle.
- Holds the pipeline with stall while a transfer is in progress, then pulses done.
- Sits between execute and writeback; the data memory has 1-cycle synchronous read latency.

Parameters:
registerSize, 32, bits per vector lane and per memory word
vecSize, 4, lanes per vector
addrSize, 16, word-address width of data memory

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
memOp  in  2  2'b01 store, 2'b10 load, 2'b00/2'b11 no-op
baseAddr  in  addrSize  word address of lane 0
vect_in  in  vecSize x registerSize  store data (packed, lane i = vect_in[i])
mem_rdata  in  registerSize  memory read data, valid the cycle after its address
mem_addr  out  addrSize  memory word address
mem_wdata  out  registerSize  memory write data
mem_we  out  1  memory write enable
vect_loaded  out  vecSize x registerSize  last completed load result
stall  out  1  pipeline hold
done  out  1  one-cycle completion pulse

Interface (already decided): one clock, clk; reset is synchronous and active-high, reset.

Behaviour:
- Reset values: all outputs are 0, internal lane buffers are 0, and state is IDLE.
- Reset asserted mid-operation: IDLE at the next edge; no further mem_we; vect_loaded cleared to 0.
- States: IDLE, STORE, LOAD, LOAD_WAIT, DONE.
- IDLE:
  - start=1 with memOp=01 captures vect_in and baseAddr, then goes to STORE.
  - start=1 with memOp=10 captures baseAddr, then goes to LOAD.
  - Any other memOp: stays in IDLE with no stall.
- STORE (lane counter k = 0..vecSize-1, one per cycle):
  - mem_we=1, mem_addr = base+k, mem_wdata = captured lane k.
  - After k = vecSize-1, goes to DONE.
- LOAD (k = 0..vecSize-1):
  - mem_addr = base+k, mem_we=0.
  - From the second LOAD cycle onward, mem_rdata is written into buffer lane k-1.
  - After k = vecSize-1, goes to LOAD_WAIT.
- LOAD_WAIT: captures mem_rdata into lane vecSize-1, then goes to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - For a load, vect_loaded takes the buffer on the DONE-entry edge, so it is valid while done=1.
  - vect_loaded is held until the next completed load; stores never change it.
- Latency, start accepted in cycle 0:
  - Store: writes in cycles 1..vecSize, done in cycle vecSize+1.
  - Load: addresses in cycles 1..vecSize, done in cycle vecSize+2.
- stall:
  - Combinational: 1 in IDLE when start=1 and memOp is valid, and 1 in STORE, LOAD and LOAD_WAIT.
  - 0 in DONE (pipeline advances in the same cycle done is asserted) and 0 in IDLE otherwise.
- start is ignored outside IDLE, including in DONE.
- Back-to-back: a new start in the first IDLE cycle after DONE is accepted normally.
- Address arithmetic is modulo 2^addrSize; base+k wraps from all-ones to 0.
- mem_addr and mem_wdata are 0 in IDLE and DONE; mem_we is 1 only in STORE.

Decomposition:
- Shared package simd_mem_pkg holds:
  - memOp encodings MEM_NOP, MEM_STORE, MEM_LOAD;
  - the state enum mem_state_t;
  - the read latency constant MEM_RD_LAT=1.
- No sub-module is needed. The lane counter and buffer stay inline; counter width is $clog2(vecSize), minimum 1.

Test Plan:
- Store: start, memOp=01, base=0x0010, vect_in={4,3,2,1} (lane0=1) -> writes addr 0x10..0x13 with data 1,2,3,4 in cycles 1-4; done in cycle 5; stall high cycles 0-4.
- Load: memory model with mem[0x20..0x23]=0xA,0xB,0xC,0xD, start, memOp=10, base=0x0020 -> done in cycle 6; vect_loaded lanes 0..3 = 0xA,0xB,0xC,0xD; mem_we never high.
- Wrap: store with base=0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Ignore and no-op: start pulses during STORE and in DONE, plus start with memOp=00 in IDLE -> no extra transfers, stall stays 0 for the no-op, exactly one done per accepted op.
- Reset mid-load: reset asserted in cycle 2 of a load -> IDLE next cycle, all outputs 0, vect_loaded 0, no done.
- Back-to-back: store done, then load started in the next IDLE cycle -> both complete; vect_loaded equals load data, unaffected by the store.

Source files
------------

// File: rtl/vector_mem_unit_pkg.sv
// Shared definitions for the vector memory stage: memOp encodings, FSM states
// and the data-memory read latency.
package simd_mem_pkg;

  localparam logic [1:0] MEM_NOP   = 2'b00;
  localparam logic [1:0] MEM_STORE = 2'b01;
  localparam logic [1:0] MEM_LOAD  = 2'b10;

  localparam int unsigned MEM_RD_LAT = 1;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD,
    LOAD_WAIT,
    DONE
  } mem_state_t;

endpackage

// File: rtl/vector_mem_unit.sv
// Vector memory stage: serialises one vector to/from a word-wide data memory,
// one lane per cycle, stalling the pipeline until the transfer completes.
module vector_mem_unit
  import simd_mem_pkg::*;
#(
  parameter int registerSize = 32,
  parameter int vecSize      = 4,
  parameter int addrSize     = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [1:0]                            memOp,
  input  logic [addrSize-1:0]                   baseAddr,
  input  logic [vecSize-1:0][registerSize-1:0]  vect_in,
  input  logic [registerSize-1:0]               mem_rdata,
  output logic [addrSize-1:0]                   mem_addr,
  output logic [registerSize-1:0]               mem_wdata,
  output logic                                  mem_we,
  output logic [vecSize-1:0][registerSize-1:0]  vect_loaded,
  output logic                                  stall,
  output logic                                  done
);

  localparam int CW = (vecSize > 1) ? $clog2(vecSize) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(vecSize - 1);

  mem_state_t state, state_n;
  logic [CW-1:0] k;
  logic [addrSize-1:0] base;
  logic [vecSize-1:0][registerSize-1:0] wbuf;
  logic [vecSize-1:0][registerSize-1:0] lbuf;
  logic [vecSize-1:0][registerSize-1:0] lbuf_fin;

  // Final load vector: buffered lanes plus the last lane arriving this cycle.
  always_comb begin
    lbuf_fin = lbuf;
    lbuf_fin[vecSize-1] = mem_rdata;
  end

  // Next-state and memory/pipeline outputs, decoded from the current state.
  always_comb begin
    state_n   = state;
    stall     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start && memOp == MEM_STORE) begin
          stall   = 1'b1;
          state_n = STORE;
        end else if (start && memOp == MEM_LOAD) begin
          stall   = 1'b1;
          state_n = LOAD;
        end
      end
      STORE: begin
        stall     = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = base + addrSize'(k);
        mem_wdata = wbuf[k];
        if (k == K_LAST) state_n = DONE;
      end
      LOAD: begin
        stall    = 1'b1;
        mem_addr = base + addrSize'(k);
        if (k == K_LAST) state_n = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        stall   = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register, lane counter, operand capture and load buffers.
  // Read data lags its address by one cycle, so lane k-1 lands while lane k is
  // addressed and the last lane lands in LOAD_WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      k           <= '0;
      base        <= '0;
      wbuf        <= '0;
      lbuf        <= '0;
      vect_loaded <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          k <= '0;
          if (start && memOp == MEM_STORE) begin
            base <= baseAddr;
            wbuf <= vect_in;
          end else if (start && memOp == MEM_LOAD) begin
            base <= baseAddr;
          end
        end
        STORE: k <= k + CW'(1);
        LOAD: begin
          if (k != '0) lbuf[k - CW'(1)] <= mem_rdata;
          k <= k + CW'(1);
        end
        LOAD_WAIT: begin
          lbuf        <= lbuf_fin;
          vect_loaded <= lbuf_fin;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_unit.sv
// Self-checking bench for vector_mem_unit: directed table, hand-written reset
// sequence and randomized ops against a transaction-level reference model.
module tb_vector_mem_unit;
  localparam int RS = 32;
  localparam int VS = 4;
  localparam int AS = 16;

  typedef logic [VS-1:0][RS-1:0] vec_t;

  typedef struct {
    logic [1:0]    op;
    logic [AS-1:0] base;
    vec_t          vec;
    bit            junk;
    int            exp_done;
  } op_rec_t;

  logic clk = 1'b0;
  logic reset, start;
  logic [1:0] memOp;
  logic [AS-1:0] baseAddr;
  vec_t vect_in;
  logic [RS-1:0] mem_rdata;
  logic [AS-1:0] mem_addr;
  logic [RS-1:0] mem_wdata;
  logic mem_we;
  vec_t vect_loaded;
  logic stall, done;

  int n_cmp = 0;
  int n_err = 0;

  logic [RS-1:0] mem [0:(1<<AS)-1];
  logic [RS-1:0] ref_mem [0:(1<<AS)-1];
  vec_t last_loaded;

  vector_mem_unit #(.registerSize(RS), .vecSize(VS), .addrSize(AS)) dut (
    .clk(clk), .reset(reset), .start(start), .memOp(memOp),
    .baseAddr(baseAddr), .vect_in(vect_in), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .vect_loaded(vect_loaded), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    start = 1'b0; memOp = 2'b00;
    #1;
    chk({tag, " stall"}, 128'(stall), 128'(0));
    chk({tag, " we"},    128'(mem_we), 128'(0));
    chk({tag, " done"},  128'(done), 128'(0));
    chk({tag, " vl"},    vect_loaded, last_loaded);
  endtask

  // Applies one op starting in an IDLE cycle and checks every cycle up to done.
  task automatic do_op(input logic [1:0] op, input logic [AS-1:0] base,
                       input vec_t vec, input bit junk, input int exp_done);
    bit is_st, is_ld;
    vec_t new_loaded;
    logic [AS-1:0] a;
    logic [AS-1:0] e_addr;
    logic [RS-1:0] e_wd;
    bit e_we, e_done;
    is_st = (op == 2'b01);
    is_ld = (op == 2'b10);
    new_loaded = last_loaded;
    for (int i = 0; i < VS; i++) begin
      a = base + AS'(i);
      if (is_ld) new_loaded[i] = ref_mem[a];
      if (is_st) ref_mem[a] = vec[i];
    end

    @(negedge clk);
    start = 1'b1; memOp = op; baseAddr = base; vect_in = vec;
    #1;
    chk("c0 stall", 128'(stall), 128'(is_st || is_ld));
    if (!(is_st || is_ld)) begin
      idle_check("nop");
      return;
    end

    for (int cyc = 1; cyc <= exp_done; cyc++) begin
      @(negedge clk);
      start = junk; memOp = junk ? 2'($urandom_range(1, 2)) : 2'b00;
      baseAddr = AS'($urandom); vect_in = {$urandom, $urandom, $urandom, $urandom};
      #1;
      e_we   = is_st && cyc <= VS;
      e_addr = (cyc <= VS) ? base + AS'(cyc - 1) : '0;
      e_wd   = e_we ? vec[cyc-1] : '0;
      e_done = (cyc == exp_done);
      chk($sformatf("c%0d we", cyc),    128'(mem_we), 128'(e_we));
      chk($sformatf("c%0d addr", cyc),  128'(mem_addr), 128'(e_addr));
      chk($sformatf("c%0d wdata", cyc), 128'(mem_wdata), 128'(e_wd));
      chk($sformatf("c%0d done", cyc),  128'(done), 128'(e_done));
      chk($sformatf("c%0d stall", cyc), 128'(stall), 128'(!e_done));
      chk($sformatf("c%0d vl", cyc),    vect_loaded, (is_ld && e_done) ? new_loaded : last_loaded);
    end
    last_loaded = new_loaded;
    if (junk) idle_check("post-junk");
  endtask

  op_rec_t tbl [8];

  initial begin
    for (int i = 0; i < (1 << AS); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < VS; i++) begin
      mem[16'h0020 + i]     = 32'hA + i;
      ref_mem[16'h0020 + i] = 32'hA + i;
    end
    last_loaded = '0;

    tbl[0] = '{2'b01, 16'h0010, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 5};
    tbl[1] = '{2'b10, 16'h0020, '0, 1'b0, 6};
    tbl[2] = '{2'b01, 16'hFFFE, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, 5};
    tbl[3] = '{2'b00, 16'h0030, {32'h9, 32'h9, 32'h9, 32'h9}, 1'b0, 0};
    tbl[4] = '{2'b11, 16'h0030, {32'h8, 32'h8, 32'h8, 32'h8}, 1'b0, 0};
    tbl[5] = '{2'b01, 16'h0040, {32'hDEAD, 32'hBEEF, 32'hCAFE, 32'hF00D}, 1'b1, 5};
    tbl[6] = '{2'b10, 16'hFFFE, '0, 1'b1, 6};
    tbl[7] = '{2'b10, 16'h0040, '0, 1'b0, 6};

    reset = 1'b1; start = 1'b0; memOp = 2'b00; baseAddr = '0; vect_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst we",    128'(mem_we), 128'(0));
    chk("rst addr",  128'(mem_addr), 128'(0));
    chk("rst wdata", 128'(mem_wdata), 128'(0));
    chk("rst stall", 128'(stall), 128'(0));
    chk("rst done",  128'(done), 128'(0));
    chk("rst vl",    vect_loaded, '0);

    for (int t = 0; t < 8; t++)
      do_op(tbl[t].op, tbl[t].base, tbl[t].vec, tbl[t].junk, tbl[t].exp_done);

    // Reset arrives in cycle 2 of a load.
    @(negedge clk);
    start = 1'b1; memOp = 2'b10; baseAddr = 16'h0020;
    @(negedge clk);
    start = 1'b0; memOp = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    last_loaded = '0;
    chk("mrst we",    128'(mem_we), 128'(0));
    chk("mrst addr",  128'(mem_addr), 128'(0));
    chk("mrst wdata", 128'(mem_wdata), 128'(0));
    chk("mrst stall", 128'(stall), 128'(0));
    chk("mrst done",  128'(done), 128'(0));
    chk("mrst vl",    vect_loaded, '0);
    for (int i = 0; i < 4; i++) idle_check("post-rst");

    // Back-to-back: store then load in the first IDLE cycle after done.
    do_op(2'b01, 16'h0080, {32'h5, 32'h6, 32'h7, 32'h8}, 1'b0, 5);
    do_op(2'b10, 16'h0020, '0, 1'b0, 6);
    do_op(2'b10, 16'h0080, '0, 1'b0, 6);

    // Randomized ops; bases cluster in a small window so loads see stored data.
    for (int r = 0; r < 40; r++) begin
      logic [1:0] op;
      logic [AS-1:0] b;
      op = 2'($urandom_range(0, 3));
      b = ($urandom_range(0, 1) == 1) ? 16'hFFFC + AS'($urandom_range(0, 6))
                                      : AS'($urandom);
      do_op(op, b, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
            (op == 2'b01) ? VS + 1 : (op == 2'b10) ? VS + 2 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
